// File: rtl/ysyx_25060166_ifu.sv
// Instruction fetch unit for the RV32E NPC: PC register, one-outstanding imem fetch, valid/ready hand-off to IDU.
// Optional misaligned-PC trapping is enabled by defining YSYX_25060166_IFU_MISALIGN_TRAP_EN.
module ysyx_25060166_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            inst_fault_r;
  logic            inst_valid_r;
  logic [XLEN-1:0] redirect_tgt_s;
  logic            misalign_s;
  logic            req_fire_s;

`ifdef YSYX_25060166_IFU_MISALIGN_TRAP_EN
  assign redirect_tgt_s = redirect_pc;
  assign misalign_s     = (pc_r[1:0] != 2'b00);
`else
  // Without trapping, the low two bits are dropped so the PC can never become misaligned.
  assign redirect_tgt_s = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign misalign_s     = 1'b0;
`endif

  assign imem_req_valid = (state_r == S_REQ) && !misalign_s && !rst;
  assign imem_req_addr  = pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_fault = inst_fault_r;

  // Fetch FSM: PC update (reset > redirect > pc+4), request/response tracking, IDU output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_PC;
      inst_r       <= {XLEN{1'b0}};
      inst_pc_r    <= {XLEN{1'b0}};
      inst_fault_r <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (redirect_valid) begin
            pc_r    <= redirect_tgt_s;
            state_r <= req_fire_s ? S_DROP : S_REQ;
          end else if (misalign_s) begin
            inst_r       <= {XLEN{1'b0}};
            inst_pc_r    <= pc_r;
            inst_fault_r <= 1'b1;
            inst_valid_r <= 1'b1;
            state_r      <= S_HOLD;
          end else if (req_fire_s) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_r    <= redirect_tgt_s;
            state_r <= imem_resp_valid ? S_REQ : S_DROP;
          end else if (imem_resp_valid) begin
            inst_r       <= imem_resp_err ? {XLEN{1'b0}} : imem_resp_data;
            inst_pc_r    <= pc_r;
            inst_fault_r <= imem_resp_err;
            inst_valid_r <= 1'b1;
            state_r      <= S_HOLD;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DROP: begin
          if (redirect_valid) begin
            pc_r <= redirect_tgt_s;
          end else begin
            pc_r <= pc_r;
          end
          state_r <= imem_resp_valid ? S_REQ : S_DROP;
        end
        S_HOLD: begin
          // A redirect wins over pc+4 even when the IDU consumes in the same cycle.
          if (redirect_valid) begin
            pc_r         <= redirect_tgt_s;
            inst_valid_r <= 1'b0;
            state_r      <= S_REQ;
          end else if (inst_ready) begin
            pc_r         <= pc_r + {{(XLEN-3){1'b0}}, 3'b100};
            inst_valid_r <= 1'b0;
            state_r      <= S_REQ;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          inst_valid_r <= 1'b0;
          state_r      <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060166_ifu.sv
// Directed bench for ysyx_25060166_ifu: behavioural imem with per-request latency, vector table plus corner sequences.
module tb_ysyx_25060166_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  always #5 clk = ~clk;

  ysyx_25060166_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  int          checks = 0;
  int          errors = 0;
  bit          pending = 1'b0;
  int          pend_cnt = 0;
  int          lat = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_req_addr = 32'h0;
  logic [31:0] err_addr = 32'h8000_0008;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic        rdy;
    logic [31:0] req_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs [6];

  // Memory contents: reset vector holds addi x1,x0,1; elsewhere the low address half tags the word.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] w;
    w = (a == 32'h8000_0000) ? 32'h0010_0093 : {a[15:0], 16'h0013};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive memory response, sample handshakes at negedge, update the memory model after the edge.
  task automatic step();
    logic acc;
    logic fire;
    imem_resp_valid = pending && (pend_cnt == 0);
    imem_resp_data  = pending ? mem_data(pend_addr) : 32'h0;
    imem_resp_err   = pending && (pend_addr == err_addr);
    @(negedge clk);
    acc  = imem_req_valid && imem_req_ready;
    fire = imem_resp_valid;
    if (acc) begin
      last_req_addr = imem_req_addr;
      if (pending && !fire) begin
        checks++;
        errors++;
        $display("FAIL outstanding: second request %h accepted while %h pending", imem_req_addr, pend_addr);
      end
    end
    @(posedge clk);
    #1;
    if (fire) pending = 1'b0;
    else if (pending && pend_cnt > 0) pend_cnt--;
    if (acc) begin
      pending   = 1'b1;
      pend_addr = last_req_addr;
      pend_cnt  = lat;
    end
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc,
                             input logic e_fault);
    int n;
    n = 0;
    while (!inst_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, ".valid"}, {31'b0, inst_valid}, 32'h1);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".pc"}, inst_pc, e_pc);
    chk({tag, ".fault"}, {31'b0, inst_fault}, {31'b0, e_fault});
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h8000_0040, 0, 1'b0, 32'h8000_0040, 32'h0040_0013, 32'h8000_0040, 1'b0};
    vecs[1] = '{32'h8000_0008, 2, 1'b1, 32'h8000_0008, 32'h0000_0000, 32'h8000_0008, 1'b1};
    vecs[2] = '{32'h1234_5678, 1, 1'b0, 32'h1234_5678, 32'h5678_0013, 32'h1234_5678, 1'b0};
`ifdef YSYX_25060166_IFU_MISALIGN_TRAP_EN
    vecs[3] = '{32'h8000_0102, 0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h8000_0102, 1'b1};
    vecs[4] = '{32'h0000_0FFF, 3, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0FFF, 1'b1};
`else
    vecs[3] = '{32'h8000_0102, 0, 1'b1, 32'h8000_0100, 32'h0100_0013, 32'h8000_0100, 1'b0};
    vecs[4] = '{32'h0000_0FFF, 3, 1'b0, 32'h0000_0FFC, 32'h0FFC_0013, 32'h0000_0FFC, 1'b0};
`endif
    vecs[5] = '{32'hFFFF_FFFC, 0, 1'b1, 32'hFFFF_FFFC, 32'hFFFC_0013, 32'hFFFF_FFFC, 1'b0};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; imem_resp_err = 1'b0; inst_ready = 1'b0;

    // Reset state and first zero-wait fetch.
    step();
    chk("rst.req_valid", {31'b0, imem_req_valid}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rst.inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.inst_pc", inst_pc, 32'h0);
    chk("rst.fault", {31'b0, inst_fault}, 32'h0);
    chk("first.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first.req_addr", imem_req_addr, 32'h8000_0000);
    step();
    chk("wait.req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("wait.inst_valid", {31'b0, inst_valid}, 32'h0);
    step();
    chk("first.valid", {31'b0, inst_valid}, 32'h1);
    chk("first.inst", inst, 32'h0010_0093);
    chk("first.pc", inst_pc, 32'h8000_0000);
    consume();
    chk("seq.req_addr", imem_req_addr, 32'h8000_0004);

    // IDU back-pressure for 5 cycles.
    expect_inst("stall", 32'h0004_0013, 32'h8000_0004, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.inst", inst, 32'h0004_0013);
      chk("stall.pc", inst_pc, 32'h8000_0004);
      chk("stall.req_valid", {31'b0, imem_req_valid}, 32'h0);
    end
    consume();
    chk("stall.next_addr", imem_req_addr, 32'h8000_0008);

    // Access fault response.
    expect_inst("err", 32'h0, 32'h8000_0008, 1'b1);
    consume();
    chk("err.next_addr", imem_req_addr, 32'h8000_000C);

    // Redirect while waiting: stale response must be dropped.
    lat = 2;
    step();
    chk("drop.req_valid", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("drop.inst_valid0", {31'b0, inst_valid}, 32'h0);
    step();
    chk("drop.inst_valid1", {31'b0, inst_valid}, 32'h0);
    step();
    chk("drop.inst_valid2", {31'b0, inst_valid}, 32'h0);
    chk("drop.req_valid2", {31'b0, imem_req_valid}, 32'h1);
    chk("drop.req_addr", imem_req_addr, 32'h8000_0100);
    lat = 0;
    expect_inst("drop", 32'h0100_0013, 32'h8000_0100, 1'b0);

    // Redirect vectors applied from S_HOLD.
    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      redirect_valid = 1'b1; redirect_pc = vecs[i].target; inst_ready = vecs[i].rdy;
      step();
      redirect_valid = 1'b0; inst_ready = 1'b0;
      chk($sformatf("vec%0d.cleared", i), {31'b0, inst_valid}, 32'h0);
      last_req_addr = 32'hDEAD_BEEF;
      expect_inst($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_fault);
      chk($sformatf("vec%0d.req_addr", i), last_req_addr, vecs[i].req_addr);
    end

    // pc+4 wraps from FFFF_FFFC.
    consume();
    chk("wrap.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("wrap.req_addr", imem_req_addr, 32'h0000_0000);

    // Redirect coinciding with the response in S_WAIT: discard and refetch directly.
    lat = 0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("wresp.inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("wresp.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("wresp.req_addr", imem_req_addr, 32'h8000_0200);
    expect_inst("wresp", 32'h0200_0013, 32'h8000_0200, 1'b0);

    // Reset mid-transaction: the orphan response arrives in S_REQ and is ignored.
    consume();
    lat = 2;
    step();
    rst = 1'b1;
    step();
    chk("mid.req_valid_rst", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b0; imem_req_ready = 1'b0;
    step();
    step();
    chk("mid.inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("mid.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("mid.req_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1; lat = 0;
    expect_inst("mid", 32'h0010_0093, 32'h8000_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
